// File: rtl/burst_memory_responder_if.sv
// Avalon-MM slave bundle between the instruction cache's memory port and the
// burst memory responder.
interface burst_memory_responder_if;
  logic [31:0] slave_address;
  logic        slave_read;
  logic        slave_write;
  logic [63:0] slave_writedata;
  logic [7:0]  slave_byteenable;
  logic [3:0]  slave_burstcount;
  logic        slave_waitrequest;
  logic [63:0] slave_readdata;
  logic        slave_readdatavalid;

  modport slave (
    input  slave_address, slave_read, slave_write, slave_writedata,
           slave_byteenable, slave_burstcount,
    output slave_waitrequest, slave_readdata, slave_readdatavalid
  );

  modport master (
    output slave_address, slave_read, slave_write, slave_writedata,
           slave_byteenable, slave_burstcount,
    input  slave_waitrequest, slave_readdata, slave_readdatavalid
  );
endinterface

// File: rtl/burst_memory_responder.sv
// 64-bit on-chip RAM serving incrementing Avalon-MM read bursts with
// configurable accept stall and read latency; single-beat byte-enabled writes.
module burst_memory_responder #(
  parameter int addr_width_words = 12,
  parameter int read_latency     = 2,
  parameter int accept_delay     = 0
) (
  input logic                     clock,
  input logic                     reset,
  burst_memory_responder_if.slave bus
);
  localparam int         depth       = 1 << addr_width_words;
  localparam logic [3:0] lat_last    = 4'(read_latency - 1);
  localparam logic [4:0] stall_limit = 5'(accept_delay);

  typedef enum logic [1:0] {IDLE, LATENCY, BURST} state_t;
  state_t state, state_next;

  logic [63:0]                 mem [depth];
  logic [addr_width_words-1:0] in_word, addr, fetch_addr;
  logic [3:0]                  stall_cnt, lat_cnt, beats_left;
  logic                        stalling, read_accept, write_accept, load;
  logic                        unused_addr;

  assign in_word      = bus.slave_address[addr_width_words+2:3];
  assign unused_addr  = ^{bus.slave_address[31:addr_width_words+3], bus.slave_address[2:0]};
  assign stalling     = bus.slave_read & ~bus.slave_write & ({1'b0, stall_cnt} < stall_limit);
  assign read_accept  = (state == IDLE) & bus.slave_read & ~bus.slave_write & ~bus.slave_waitrequest;
  assign write_accept = (state == IDLE) & bus.slave_write & ~bus.slave_waitrequest;
  // The beat about to be presented comes straight from the request when
  // read_latency = 1, otherwise from the running burst address.
  assign fetch_addr   = (state == IDLE) ? in_word : addr;
  assign load         = (state_next == BURST);

  always_ff @(posedge clock or posedge reset)
    if (reset) state <= IDLE;
    else       state <= state_next;

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (read_accept) state_next = (read_latency == 1) ? BURST : LATENCY;
      LATENCY: if (lat_cnt == lat_last) state_next = BURST;
      BURST:   if (beats_left == 4'd1) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    bus.slave_waitrequest   = reset | (state != IDLE) | stalling;
    bus.slave_readdatavalid = ~reset & (state == BURST);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      stall_cnt          <= '0;
      lat_cnt            <= '0;
      beats_left         <= '0;
      addr               <= '0;
      bus.slave_readdata <= '0;
    end else begin
      // Saturate so a read held behind a stuck write cannot wrap the counter.
      if (state == IDLE && bus.slave_read && !read_accept && stall_cnt != 4'hF)
        stall_cnt <= stall_cnt + 4'd1;
      else if (state != IDLE || !bus.slave_read || read_accept)
        stall_cnt <= '0;

      if (read_accept) begin
        beats_left <= (bus.slave_burstcount == 4'd0) ? 4'd1 : bus.slave_burstcount;
        lat_cnt    <= 4'd1;
      end else if (state == LATENCY) begin
        lat_cnt <= lat_cnt + 4'd1;
      end else if (state == BURST) begin
        beats_left <= beats_left - 4'd1;
      end

      if (load) begin
        bus.slave_readdata <= mem[fetch_addr];
        addr               <= fetch_addr + 1'b1;
      end else if (read_accept) begin
        addr <= in_word;
      end
    end
  end

  // RAM is deliberately outside the reset domain so images survive reset.
  always_ff @(posedge clock)
    if (write_accept)
      for (int i = 0; i < 8; i++)
        if (bus.slave_byteenable[i])
          mem[in_word][8*i +: 8] <= bus.slave_writedata[8*i +: 8];
endmodule

// File: tb/tb_burst_memory_responder.sv
// Directed + randomized bench for burst_memory_responder against a word-array
// memory model and cycle-count expectations for stall, latency and beats.
module tb_burst_memory_responder;
  localparam int AW    = 10;
  localparam int RL    = 2;
  localparam int AD    = 3;
  localparam int DEPTH = 1 << AW;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  burst_memory_responder_if bus();

  burst_memory_responder #(
    .addr_width_words(AW), .read_latency(RL), .accept_delay(AD)
  ) dut (
    .clock(clock), .reset(reset), .bus(bus.slave)
  );

  logic [63:0] model [DEPTH];
  int npass  = 0;
  int ntotal = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    ntotal++;
    assert (got === exp) npass++;
    else $error("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  function automatic logic [31:0] byte_addr(input int word);
    logic [31:0] a;
    a = $urandom();
    a[AW+2:3] = word[AW-1:0];
    return a;
  endfunction

  task automatic do_write(input int word, input logic [63:0] data, input logic [7:0] be);
    @(negedge clock);
    bus.slave_address    = byte_addr(word);
    bus.slave_write      = 1'b1;
    bus.slave_writedata  = data;
    bus.slave_byteenable = be;
    bus.slave_burstcount = 4'($urandom());
    #1;
    check("write_wait", {63'd0, bus.slave_waitrequest}, 64'd0);
    @(negedge clock);
    bus.slave_write = 1'b0;
    for (int i = 0; i < 8; i++)
      if (be[i]) model[word][8*i +: 8] = data[8*i +: 8];
  endtask

  // Issue a read, wait out the accept stall, then check every cycle up to the
  // return to IDLE. In busy mode read+write stay asserted through the burst.
  task automatic do_read(input int word, input int bc, input bit busy = 1'b0,
                         input int bword = 0, input logic [63:0] bdata = '0);
    int n, stalls;
    n = (bc == 0) ? 1 : bc;
    @(negedge clock);
    bus.slave_address    = byte_addr(word);
    bus.slave_read       = 1'b1;
    bus.slave_burstcount = 4'(bc);
    #1;
    stalls = 0;
    while (bus.slave_waitrequest === 1'b1 && stalls < 20) begin
      stalls++;
      @(negedge clock);
      #1;
    end
    check("stall_len", 64'(stalls), 64'(AD));
    for (int c = 1; c <= RL + n; c++) begin
      @(negedge clock);
      if (busy) begin
        bus.slave_read       = 1'b1;
        bus.slave_write      = 1'b1;
        bus.slave_address    = byte_addr(bword);
        bus.slave_writedata  = bdata;
        bus.slave_byteenable = 8'hFF;
      end else begin
        bus.slave_read = 1'b0;
      end
      #1;
      if (c < RL) begin
        check("lat_rdv",  {63'd0, bus.slave_readdatavalid}, 64'd0);
        check("lat_wait", {63'd0, bus.slave_waitrequest},   64'd1);
      end else if (c < RL + n) begin
        check("beat_rdv",  {63'd0, bus.slave_readdatavalid}, 64'd1);
        check("beat_data", bus.slave_readdata, model[(word + c - RL) % DEPTH]);
        check("beat_wait", {63'd0, bus.slave_waitrequest},   64'd1);
      end else begin
        check("idle_rdv",  {63'd0, bus.slave_readdatavalid}, 64'd0);
        check("idle_wait", {63'd0, bus.slave_waitrequest},   64'd0);
      end
    end
    if (busy) begin
      model[bword] = bdata;
      @(negedge clock);
      bus.slave_read  = 1'b0;
      bus.slave_write = 1'b0;
    end
  endtask

  initial begin
    int stalls, extra;
    bus.slave_address    = '0;
    bus.slave_read       = 1'b0;
    bus.slave_write      = 1'b0;
    bus.slave_writedata  = '0;
    bus.slave_byteenable = '0;
    bus.slave_burstcount = '0;

    // Reset state
    #12;
    check("rst_wait", {63'd0, bus.slave_waitrequest},   64'd1);
    check("rst_rdv",  {63'd0, bus.slave_readdatavalid}, 64'd0);
    check("rst_data", bus.slave_readdata, 64'd0);
    @(negedge clock);
    reset = 1'b0;

    for (int w = 0; w < DEPTH; w++)
      do_write(w, {$urandom(), $urandom()}, 8'hFF);

    // Burst read after preload
    for (int k = 0; k < 8; k++)
      do_write(32'h200 + k, 64'h1111_0000_0000_0000 | 64'(k), 8'hFF);
    do_read(32'h200, 8);

    // Address wrap
    do_read(DEPTH - 1, 2);

    // Byte-enable merge
    do_write(32'h55, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF);
    do_write(32'h55, 64'h0123_4567_89AB_CDEF, 8'h0F);
    do_read(32'h55, 1);
    check("be_merge", bus.slave_readdata, 64'hFFFF_FFFF_89AB_CDEF);

    // Burstcount 0 means a single beat
    do_read(32'h10, 0);

    // Reset during beat 3 of an 8-beat burst
    @(negedge clock);
    bus.slave_address    = byte_addr(32'h200);
    bus.slave_read       = 1'b1;
    bus.slave_burstcount = 4'd8;
    #1;
    stalls = 0;
    while (bus.slave_waitrequest === 1'b1 && stalls < 20) begin
      stalls++;
      @(negedge clock);
      #1;
    end
    check("mid_stall", 64'(stalls), 64'(AD));
    for (int c = 1; c <= RL + 3; c++) begin
      @(negedge clock);
      bus.slave_read = 1'b0;
    end
    #1;
    check("mid_beat3_rdv",  {63'd0, bus.slave_readdatavalid}, 64'd1);
    check("mid_beat3_data", bus.slave_readdata, model[32'h203]);
    #1 reset = 1'b1;
    #1;
    check("mid_rst_rdv",  {63'd0, bus.slave_readdatavalid}, 64'd0);
    check("mid_rst_wait", {63'd0, bus.slave_waitrequest},   64'd1);
    @(negedge clock);
    @(negedge clock);
    check("mid_rst_data", bus.slave_readdata, 64'd0);
    reset = 1'b0;
    extra = 0;
    repeat (12) begin
      @(negedge clock);
      #1;
      if (bus.slave_readdatavalid !== 1'b0) extra++;
    end
    check("post_rst_beats", 64'(extra), 64'd0);
    do_read(32'h200, 8);

    // Busy rejection: write aimed at the burst's last word must not land early
    do_read(32'h300, 8, 1'b1, 32'h307, 64'hDEAD_BEEF_CAFE_F00D);
    do_read(32'h307, 1);
    check("busy_write", bus.slave_readdata, 64'hDEAD_BEEF_CAFE_F00D);

    // Randomized traffic
    for (int i = 0; i < 30; i++) begin
      if ($urandom_range(0, 2) == 0)
        do_write(int'($urandom_range(0, DEPTH - 1)), {$urandom(), $urandom()}, 8'($urandom()));
      else
        do_read(int'($urandom_range(0, DEPTH - 1)), int'($urandom_range(0, 15)));
    end

    $display("%0d/%0d checks passed", npass, ntotal);
    $finish;
  end
endmodule

// File: doc/burst_memory_responder.md
# burst_memory_responder

Avalon-MM burst read responder that sits on the memory side of the instruction cache's main-memory port. It holds a 64-bit-wide on-chip RAM and serves incrementing read bursts with waitrequest and readdatavalid. A single-beat byte-enabled write path lets the bench or a loader preload program images. One burst is outstanding at a time, and the read latency and accept stall are configurable so the cache's miss path can be exercised under different memory timings.

## Interface

**Parameters**
- `addr_width_words`, default 12: log2 of RAM depth in 64-bit words. Depth is 2^addr_width_words.
- `read_latency`, default 2: cycles from read accept to first read beat. Legal range 1..15.
- `accept_delay`, default 0: cycles waitrequest stays high on a pending read in IDLE before it is accepted. Legal range 0..15.

**Ports**
- `clock`, input, 1: clock.
- `reset`, input, 1: reset, asynchronous, active-high.
- `slave_address`, input, 32: byte address. Bits [2:0] are ignored. Word address is bits [addr_width_words+2:3].
- `slave_read`, input, 1: read burst request.
- `slave_write`, input, 1: single-beat write request.
- `slave_writedata`, input, 64: write data.
- `slave_byteenable`, input, 8: byte lanes for write. Bit n selects bits [8n+7:8n].
- `slave_burstcount`, input, 4: number of beats in a read burst.
- `slave_waitrequest`, output, 1: command not accepted this cycle.
- `slave_readdata`, output, 64: read beat data.
- `slave_readdatavalid`, output, 1: slave_readdata holds a valid beat.

## Operation

- **States:** IDLE, LATENCY, BURST.
- **slave_waitrequest** is combinational. It equals `reset | (state != IDLE) | (slave_read & ~slave_write & stall_cnt < accept_delay)`.
- **Stall counter:**
  - stall_cnt increments each IDLE cycle in which slave_read is high and the read is not accepted.
  - It clears on accept, and when slave_read is low in IDLE.
- **Write:** accepted in IDLE when slave_write is high and waitrequest is low.
  - The RAM word at the word address is updated on enabled lanes only.
  - slave_burstcount is ignored. State stays IDLE.
  - The write has no accept delay.
- **Simultaneous read and write in IDLE:** the write is accepted and the read is not. A held read is then accepted on a later cycle under the normal rules.
- **Read accept:** occurs in IDLE when slave_read is high, slave_write is low and waitrequest is low.
  - The block latches the word address and a beat count. The beat count is slave_burstcount, with 0 treated as 1.
  - It then goes to LATENCY, or directly to BURST when read_latency = 1.
- **LATENCY:** lasts read_latency-1 cycles, then transitions to BURST.
- **BURST:**
  - One beat is emitted per cycle. There is no backpressure.
  - The word address increments by 1 per beat, modulo 2^addr_width_words.
  - After the last beat, state returns to IDLE.
- **Input qualification:** inputs are ignored outside IDLE, and read/write are never queued.
- **slave_readdata:** holds the last beat's value when readdatavalid is low. Its reset value is 0.
- **RAM contents:** not cleared by reset. Contents before the first write are undefined.

## Timing

- **Reset values:** slave_readdatavalid = 0, slave_readdata = 0, slave_waitrequest = 1 while reset is high, state = IDLE, stall_cnt = 0.
- **Reset mid-operation:**
  - Assertion aborts any LATENCY/BURST immediately. readdatavalid goes low asynchronously and no further beats are produced.
  - RAM contents are retained.
- **Accept cycle:** T is the cycle with slave_read high and slave_waitrequest low.
- **Beat timing:** beat k (k = 0..N-1) has readdatavalid high at cycle T + read_latency + k, with data from word (A + k) mod depth.
- **Return to IDLE:** IDLE is reached in cycle T + read_latency + N. waitrequest is low there (when accept_delay = 0), so a new read can be accepted in that cycle.
- **accept_delay = d:** with read held from cycle S in IDLE, waitrequest is high for cycles S..S+d-1 and low at S+d. The read is accepted at S+d.
- **Write latency:** a write accepted at cycle W is visible to a read accepted at W+1 or later.
- **Mutual exclusion:** readdatavalid and waitrequest-low never coincide except in the final-beat-to-IDLE handoff described above, where readdatavalid is already low.

## Test plan

- **Burst read after preload:**
  - Stimulus: write 0x1111_0000_0000_000k to words 0x200..0x207 (byte addr 0x1000..0x1038). Then read 0x1000 with burstcount 8, read_latency 2.
  - Required: accept at T, beats k = 0..7 at T+2..T+9 with matching data, waitrequest low at T+10.
- **Accept stall:**
  - Stimulus: accept_delay 3, read held from cycle S.
  - Required: waitrequest high at S..S+2 and low at S+3. First beat at S+3+read_latency.
- **Address wrap:**
  - Stimulus: read at word depth-1 with burstcount 2.
  - Required: beat 0 = word depth-1, beat 1 = word 0.
- **Byte-enable write:**
  - Stimulus: write 0xFFFF_FFFF_FFFF_FFFF with byteenable 0xFF, then write 0x0123_4567_89AB_CDEF with byteenable 0x0F to the same word. Read 1 beat.
  - Required: readdata = 0xFFFF_FFFF_89AB_CDEF.
- **Reset mid-burst:**
  - Stimulus: assert reset during beat 3 of an 8-beat burst.
  - Required: readdatavalid low immediately, no beats after release. A new 8-beat read returns the original preloaded data.
- **Busy rejection:**
  - Stimulus: hold slave_read and slave_write high during an active burst.
  - Required: waitrequest stays high throughout, no RAM update occurs during the burst, and the write is accepted in the first IDLE cycle.
